// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: data/address widths, x0 index and a decode helper.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 2 ** AW;

    // Architectural zero register; writes to it are discarded everywhere.
    localparam logic [AW-1:0] X0_IDX = '0;

    // One register-file write-port request.
    typedef struct packed {
        logic            we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
    } rf_wr_t;

    // One-hot decode of a register index.
    function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] idx);
        logic [NREG-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/riscv_rf_write_arbiter_if.sv
// Bundle of writeback, long-latency, issue, decode and register-file signals
// around the register-file write arbiter.
interface riscv_rf_write_arbiter_if;
    import riscv_pkg::*;

    // Pipeline writeback request
    logic            wb_we;
    logic [AW-1:0]   wb_wa;
    logic [XLEN-1:0] wb_wd;
    // Long-latency result offer
    logic            lu_valid;
    logic [AW-1:0]   lu_wa;
    logic [XLEN-1:0] lu_wd;
    logic            lu_ready;
    // Long-latency issue
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    // Decode-stage operands
    logic [AW-1:0]   id_ra1;
    logic [AW-1:0]   id_ra2;
    logic [AW-1:0]   id_rd;
    logic            id_stall;
    logic            wb_block;
    // Register-file write port
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic            err_unexp;

    // Surrounding pipeline side
    modport master (
        output wb_we, wb_wa, wb_wd,
        output lu_valid, lu_wa, lu_wd,
        output iss_valid, iss_rd,
        output id_ra1, id_ra2, id_rd,
        input  lu_ready, id_stall, wb_block,
        input  rf_we, rf_wa, rf_wd, err_unexp
    );

    // Arbiter side
    modport slave (
        input  wb_we, wb_wa, wb_wd,
        input  lu_valid, lu_wa, lu_wd,
        input  iss_valid, iss_rd,
        input  id_ra1, id_ra2, id_rd,
        output lu_ready, id_stall, wb_block,
        output rf_we, rf_wa, rf_wd, err_unexp
    );

endinterface

// File: rtl/riscv_lu_wbuf.sv
// One-entry valid/ready buffer for long-latency results, with a saturating
// counter of cycles the held entry has lost the write port to writeback.
module riscv_lu_wbuf
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [AW-1:0]   in_wa,
    input  logic [XLEN-1:0] in_wd,
    output logic            in_ready,
    input  logic            wb_act,
    output logic            buf_valid,
    output logic [AW-1:0]   buf_wa,
    output logic [XLEN-1:0] buf_wd,
    output logic            drain,
    output logic            wb_block
);

    logic            valid_q, valid_d;
    logic [AW-1:0]   wa_q, wa_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic [3:0]      wait_q, wait_d;
    logic            load;

    // Handshake: the port is free whenever writeback is idle, so a held entry
    // drains and a new one can be taken in the same cycle.
    always_comb begin
        drain    = valid_q && !wb_act;
        in_ready = !rst && (!valid_q || drain);
        // Results for x0 are accepted and dropped.
        load     = in_valid && in_ready && (in_wa != X0_IDX);
    end

    // Next-state for the entry and the starvation counter.
    always_comb begin
        valid_d = valid_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        wait_d  = wait_q;
        if (load) begin
            valid_d = 1'b1;
            wa_d    = in_wa;
            wd_d    = in_wd;
        end else if (drain) begin
            valid_d = 1'b0;
        end
        if (!valid_q || drain) begin
            wait_d = 4'd0;
        end else if (wait_q != 4'hF) begin
            // Held and not draining means writeback took the port.
            wait_d = wait_q + 4'd1;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            wait_q  <= 4'd0;
        end else begin
            valid_q <= valid_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are pure state so wb_block has no path from wb_we.
    always_comb begin
        buf_valid = valid_q;
        buf_wa    = wa_q;
        buf_wd    = wd_q;
        wb_block  = (wait_q >= 4'(STARVE_MAX));
    end

endmodule

// File: rtl/riscv_rf_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, long-latency
// results wait in a one-entry buffer; a scoreboard stalls decode on
// destinations still in flight.
module riscv_rf_write_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                     clk,
    input logic                     rst,
    riscv_rf_write_arbiter_if.slave bus
);

    logic            wb_act;
    logic            lu_ready;
    logic            lu_accept;
    logic            buf_valid;
    logic [AW-1:0]   buf_wa;
    logic [XLEN-1:0] buf_wd;
    logic            drain;
    logic            wb_block;
    logic [NREG-1:0] busy_q, busy_d, busy_eff;
    logic            err_q, err_d;
    rf_wr_t          wr;

    assign wb_act = bus.wb_we && (bus.wb_wa != X0_IDX);

    riscv_lu_wbuf #(
        .STARVE_MAX (STARVE_MAX)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.lu_valid),
        .in_wa     (bus.lu_wa),
        .in_wd     (bus.lu_wd),
        .in_ready  (lu_ready),
        .wb_act    (wb_act),
        .buf_valid (buf_valid),
        .buf_wa    (buf_wa),
        .buf_wd    (buf_wd),
        .drain     (drain),
        .wb_block  (wb_block)
    );

    assign lu_accept = bus.lu_valid && lu_ready;

    // Write-port mux: writeback first, then the buffer; nothing under reset.
    always_comb begin
        wr = '0;
        if (!rst) begin
            if (wb_act) begin
                wr = '{we: 1'b1, wa: bus.wb_wa, wd: bus.wb_wd};
            end else if (buf_valid) begin
                wr = '{we: 1'b1, wa: buf_wa, wd: buf_wd};
            end
        end
    end

    // Scoreboard next-state: clear on drain, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (drain) begin
            busy_d[buf_wa] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != X0_IDX)) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[X0_IDX] = 1'b0;
    end

    // Sticky flag for a result nobody was waiting on.
    always_comb begin
        err_d = err_q;
        if (lu_accept && (bus.lu_wa != X0_IDX) && !busy_q[bus.lu_wa]) begin
            err_d = 1'b1;
        end
    end

    // Scoreboard and error state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    // Hazard check; a register draining this cycle is forwarded by the RF.
    always_comb begin
        busy_eff = busy_q & ~(drain ? reg_onehot(buf_wa) : '0);
        busy_eff[X0_IDX] = 1'b0;
        bus.id_stall = busy_eff[bus.id_ra1] | busy_eff[bus.id_ra2] | busy_eff[bus.id_rd];
    end

    // Remaining outputs.
    always_comb begin
        bus.lu_ready  = lu_ready;
        bus.wb_block  = wb_block;
        bus.rf_we     = wr.we;
        bus.rf_wa     = wr.wa;
        bus.rf_wd     = wr.wd;
        bus.err_unexp = err_q;
    end

endmodule

// File: doc/riscv_rf_write_arbiter.md
# riscv_rf_write_arbiter

Shares the single register-file write port between the in-order pipeline's writeback stage and a long-latency unit (mul/div, non-blocking load return) that completes out of order. Holds a scoreboard of destination registers with results still in flight, stalls decode on RAW/WAW hazards against them, and buffers one long-latency result until a free write slot exists. Sits between MEM/WB, the long-latency unit and the register file.

## Interface
- XLEN, 32: data width.
- AW, 5: register address width; NREG = 2**AW.
- STARVE_MAX, 4: cycles a buffered result may lose to writeback before `wb_block` asserts; range 1..15.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_we / wb_wa / wb_wd  in  1/AW/XLEN  pipeline writeback request; never stalled.
- lu_valid / lu_wa / lu_wd  in  1/AW/XLEN  long-latency result offer.
- lu_ready  out  1  result accepted when `lu_valid && lu_ready`.
- iss_valid / iss_rd  in  1/AW  long-latency op issued this cycle (caller qualifies with `!id_stall`).
- id_ra1 / id_ra2 / id_rd  in  AW each  decode-stage source and destination addresses.
- id_stall  out  1  decode must hold.
- wb_block  out  1  pipeline must insert a bubble into MEM/WB: `wb_we` = 0 next cycle.
- rf_we / rf_wa / rf_wd  out  1/AW/XLEN  drive the register-file write port.
- err_unexp  out  1  sticky: result arrived for a register not marked busy.

## Operation
- State: `busy[NREG-1:1]`, one-entry buffer (`buf_valid`, `buf_wa`, `buf_wd`), `wait_cnt` (4 bits, saturating), `err_unexp`.
- `wb_act = wb_we && wb_wa != 0`. `drain = buf_valid && !wb_act`.
- Write port is combinational. If `wb_act`, pass the WB request. Else if `buf_valid`, write the buffer. Else `rf_we` = 0.
- `lu_ready = !buf_valid || drain`. Accept loads the buffer; accept and drain in the same cycle are allowed (full throughput).
- `lu_wa == 0`: accepted, never written. The buffer stays empty for it and it sets no error.
- Scoreboard set: `iss_valid && iss_rd != 0` sets `busy[iss_rd]`.
- Scoreboard clear: `drain` clears `busy[buf_wa]`. If the same index is set and cleared in one cycle, set wins.
- Hazard: `busy_eff = busy` with `buf_wa` masked off when `drain`. The register file forwards same-cycle writes, so no stall is needed in that case.
- `id_stall = busy_eff[id_ra1] | busy_eff[id_ra2] | busy_eff[id_rd]`. Index 0 never stalls.
- Starvation: `wait_cnt` increments when `buf_valid && wb_act` and clears on drain or empty buffer. `wb_block = (wait_cnt >= STARVE_MAX)`.
- Error: an accepted result with `lu_wa != 0` and `busy[lu_wa] == 0` sets `err_unexp`. Only reset clears it. The data is still written.

## Timing
- Reset while `rst` high: busy = 0, `buf_valid` = 0, `wait_cnt` = 0, `err_unexp` = 0. Outputs `rf_we` = 0 (WB ignored), `lu_ready` = 0, `id_stall` = 0, `wb_block` = 0.
- Mid-operation reset discards the buffered result and all busy bits. The long-latency unit must share `rst`.
- Latency: a result accepted in cycle N is written in N+1 at the earliest. `id_stall` on that register drops in N+1; its busy bit clears at edge N+1→N+2.
- Issue in cycle N: `busy` is visible from N+1. Decode of a dependent op in N+1 stalls.
- Contention: WB always wins. The buffered result waits at most STARVE_MAX cycles plus one bubble cycle.
- `wb_block` is a registered-state function (no combinational path from `wb_we`). `lu_ready` and the `rf_*` outputs do depend combinationally on `wb_we`/`wb_wa`.

## Structure
- Shared package `riscv_pkg`: XLEN, AW, NREG constants; also the x0 index constant used by the register file and this block.
- One sub-module: `riscv_lu_wbuf`, the one-entry valid/ready buffer with the starvation counter. Scoreboard and mux stay in the top.

## Test plan
- Reset: hold `rst` with `wb_we=1, wb_wa=3` → `rf_we=0`, `lu_ready=0`, `id_stall=0`. After release → `lu_ready=1`.
- RAW: `iss_rd=5` in cycle 0; `id_ra1=5` in cycle 1 → `id_stall=1`. `lu_wa=5, lu_wd=0xDEADBEEF` accepted in cycle 3, WB idle → cycle 4: `rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF`, `id_stall=0`.
- Starvation: buffer holds x7 while `wb_we=1, wb_wa=3` every cycle → WB written each cycle, `wb_block=1` after 4 cycles. Bench drops `wb_we` next cycle → x7 written, `wb_block=0`.
- Throughput: busy x1 and x2, `lu_valid` two consecutive cycles, WB idle → `lu_ready` stays 1, writes to x1 then x2 on consecutive cycles.
- x0 and WB x0: `lu_wa=0` accepted → no write. Buffered x4 with `wb_we=1, wb_wa=0` → x4 drains that cycle.
- Unexpected result: `lu_wa=9` with x9 not busy → `err_unexp=1` next cycle and stays 1; x9 still written.
